// File: rtl/sram_controller_if.sv
// sram_controller_if
//   Groups the pipeline-side request bus and the SRAM pin bus of one
//   sram_controller instance.
//   Pipeline side : wr_en, rd_en, address, write_data -> ; <- read_data, ready
//   SRAM side     : <- sram_addr, sram_dq_out, sram_dq_oe, sram_we_n ; sram_dq_in ->
//   master : the environment (pipeline + SRAM device) driving the controller
//   slave  : the controller itself
// Handshake: a request is a level on wr_en/rd_en. It is accepted on the rising
// edge that ends an IDLE cycle in which it is present. ready is low from that
// IDLE cycle until the access finishes, and high for one DONE cycle. The
// requester holds or drops its request freely after acceptance. It has no
// effect until the controller is back in IDLE.
interface sram_controller_if #(
  parameter int ADDR_W = 18
);
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic [15:0]       sram_dq_in;
  logic              sram_dq_oe;
  logic              sram_we_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller
//   Splits one 32-bit load/store from the MEM stage into two 16-bit accesses
//   to an asynchronous SRAM. The low half-word goes first, then the high
//   half-word. Each half is held on the pins for WAIT_CYCLES cycles.
//   While an access is in flight, ready is low and the pipeline freezes.
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : sram_controller_if.slave (request bus + SRAM pins)
//   state_dbg : current FSM state (0=IDLE, 1=LOW, 2=HIGH, 3=DONE)
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_W      = 18,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t       state;
  state_t       next_state;
  logic [3:0]   cnt;
  logic [31:0]  lat_addr;
  logic [31:0]  lat_wdata;
  logic         lat_wr;
  logic [31:0]  read_q;

  logic [31:0]       eff;
  logic [ADDR_W-2:0] word;
  logic              req;
  logic              cnt_last;

  // Data memory starts at MEM_BASE. The subtraction wraps, and the slice
  // silently drops any bits above the SRAM's range.
  assign eff      = lat_addr - MEM_BASE;
  assign word     = eff[ADDR_W:2];
  assign req      = bus.rd_en | bus.wr_en;
  assign cnt_last = (cnt == CNT_LAST);

  logic unused_eff;
  assign unused_eff = ^{eff[31:ADDR_W+1], eff[1:0]};

  assign bus.read_data = read_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      read_q    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= bus.address;
            lat_wdata <= bus.write_data;
            // With both requests high, the access is a store.
            lat_wr    <= bus.wr_en;
            cnt       <= '0;
          end
        end
        LOW: begin
          if (cnt_last) begin
            cnt <= '0;
            if (!lat_wr) read_q[15:0] <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt_last) begin
            cnt <= '0;
            if (!lat_wr) read_q[31:16] <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    next_state      = state;
    bus.ready       = 1'b0;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        bus.ready = ~req;
        if (req) next_state = LOW;
      end
      LOW: begin
        bus.sram_addr = {word, 1'b0};
        if (lat_wr) begin
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_oe  = 1'b1;
          bus.sram_dq_out = lat_wdata[15:0];
        end
        if (cnt_last) next_state = HIGH;
      end
      HIGH: begin
        bus.sram_addr = {word, 1'b1};
        if (lat_wr) begin
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_oe  = 1'b1;
          bus.sram_dq_out = lat_wdata[31:16];
        end
        if (cnt_last) next_state = DONE;
      end
      DONE: begin
        // Return to IDLE unconditionally. The request is still high while
        // the pipeline advances, and it must not start a second access here.
        bus.ready  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Two controller instances share one behavioural SRAM.
//   dut_a uses WAIT_CYCLES=2 and dut_b uses WAIT_CYCLES=1. sel picks which
//   one the driver talks to. The reference model is a word-addressed array
//   indexed by ((address - 1024) >> 2) mod 2^17.
module tb_sram_controller;
  localparam int ADDR_W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sram_controller_if #(.ADDR_W(ADDR_W)) bus_a ();
  sram_controller_if #(.ADDR_W(ADDR_W)) bus_b ();
  logic [1:0] state_a, state_b;

  sram_controller #(.WAIT_CYCLES(2), .ADDR_W(ADDR_W), .MEM_BASE(32'd1024)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a));
  sram_controller #(.WAIT_CYCLES(1), .ADDR_W(ADDR_W), .MEM_BASE(32'd1024)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b));

  // ---------------- request drive ----------------
  bit          sel = 1'b0;
  logic        req_wr = 1'b0, req_rd = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  assign bus_a.wr_en      = !sel && req_wr;
  assign bus_a.rd_en      = !sel && req_rd;
  assign bus_a.address    = req_addr;
  assign bus_a.write_data = req_wdata;
  assign bus_b.wr_en      = sel && req_wr;
  assign bus_b.rd_en      = sel && req_rd;
  assign bus_b.address    = req_addr;
  assign bus_b.write_data = req_wdata;

  logic              obs_ready, obs_we_n, obs_oe;
  logic [ADDR_W-1:0] obs_addr;
  logic [15:0]       obs_dq_out;
  logic [31:0]       obs_rd;
  logic [1:0]        obs_state;
  assign obs_ready  = sel ? bus_b.ready       : bus_a.ready;
  assign obs_we_n   = sel ? bus_b.sram_we_n   : bus_a.sram_we_n;
  assign obs_oe     = sel ? bus_b.sram_dq_oe  : bus_a.sram_dq_oe;
  assign obs_addr   = sel ? bus_b.sram_addr   : bus_a.sram_addr;
  assign obs_dq_out = sel ? bus_b.sram_dq_out : bus_a.sram_dq_out;
  assign obs_rd     = sel ? bus_b.read_data   : bus_a.read_data;
  assign obs_state  = sel ? state_b           : state_a;

  // ---------------- asynchronous SRAM model ----------------
  bit [15:0] sram_mem [0:(1<<ADDR_W)-1];
  bit        preloaded = 1'b0;
  assign bus_a.sram_dq_in = sram_mem[bus_a.sram_addr];
  assign bus_b.sram_dq_in = sram_mem[bus_b.sram_addr];

  always @(posedge clk) begin
    if (!preloaded) begin
      sram_mem[2] <= 16'h5678;
      sram_mem[3] <= 16'h1234;
      preloaded   <= 1'b1;
    end
    if (!bus_a.sram_we_n) sram_mem[bus_a.sram_addr] <= bus_a.sram_dq_out;
    if (!bus_b.sram_we_n) sram_mem[bus_b.sram_addr] <= bus_b.sram_dq_out;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] last_read [2];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] eff;
    eff = a - 32'd1024;
    return int'((eff >> 2) % 32'(1 << (ADDR_W - 1)));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete access, checked cycle by cycle from the request cycle (k=0)
  // to DONE (k=2*wc+1). With hold=0 the request inputs are scrambled while
  // the access runs and cleared in DONE. With hold=1 they stay up into DONE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    int wc;
    int word;
    bit half;
    wc   = sel ? 1 : 2;
    word = word_of(addr);
    if (!wr) exp_q.push_back(ref_mem.exists(word) ? ref_mem[word] : 32'h0);
    @(negedge clk);
    req_wr = wr; req_rd = rd; req_addr = addr; req_wdata = wd;
    for (int k = 0; k <= 2 * wc + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (!hold && k <= 2 * wc) begin
          req_wr = 1'($urandom_range(0, 1)); req_rd = 1'($urandom_range(0, 1));
          req_addr = $urandom; req_wdata = $urandom;
        end else if (!hold) begin
          req_wr = 1'b0; req_rd = 1'b0;
        end
      end
      #1;
      check("ready", 32'(obs_ready), 32'(k == 2 * wc + 1));
      if (k >= 1 && k <= 2 * wc) begin
        half = (k > wc);
        check("sram_addr", 32'(obs_addr), 32'(word * 2 + int'(half)));
        check("sram_we_n", 32'(obs_we_n), 32'(!wr));
        check("sram_dq_oe", 32'(obs_oe), 32'(wr));
        if (wr) check("sram_dq_out", 32'(obs_dq_out), half ? 32'(wd[31:16]) : 32'(wd[15:0]));
      end else begin
        check("idle_we_n", 32'(obs_we_n), 32'd1);
        check("idle_dq_oe", 32'(obs_oe), 32'd0);
      end
    end
    if (!wr) last_read[sel] = exp_q.pop_front();
    check(wr ? "read_data_kept" : "read_data", obs_rd, last_read[sel]);
    if (wr) ref_mem[word] = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a + 32'h0008_0000;  // aliases the same word
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    bit w;
    last_read[0] = '0;
    last_read[1] = '0;
    ref_mem[1] = 32'h1234_5678;

    // Reset values with no request pending.
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_ready", 32'(obs_ready), 32'd1);
      check("rst_we_n", 32'(obs_we_n), 32'd1);
      check("rst_dq_oe", 32'(obs_oe), 32'd0);
      check("rst_sram_addr", 32'(obs_addr), 32'd0);
      check("rst_dq_out", 32'(obs_dq_out), 32'd0);
      check("rst_read_data", obs_rd, 32'd0);
      check("rst_state", 32'(obs_state), 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Directed accesses on dut_a (WAIT_CYCLES=2).
    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

    // Store then load at the same address, request held high through DONE.
    access(1'b1, 1'b0, 32'd1044, 32'hCAFE_F00D, 1'b1);
    access(1'b0, 1'b1, 32'd1044, 32'h0, 1'b0);

    // Quiet bus for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("quiet_ready", 32'(obs_ready), 32'd1);
      check("quiet_we_n", 32'(obs_we_n), 32'd1);
      check("quiet_dq_oe", 32'(obs_oe), 32'd0);
    end

    // Both requests high is a store.
    access(1'b1, 1'b1, 32'd1052, 32'h0BAD_F00D, 1'b0);
    access(1'b0, 1'b1, 32'd1052, 32'h0, 1'b0);

    // Address below MEM_BASE wraps, and a high alias hits the same word.
    access(1'b1, 1'b0, 32'd0, 32'h1357_9BDF, 1'b0);
    access(1'b0, 1'b1, 32'd0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1052, 32'h2468_ACE0, 1'b0);
    access(1'b0, 1'b1, 32'd1052 + 32'h0008_0000, 32'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      a = rand_addr();
      w = 1'($urandom_range(0, 1));
      access(w, !w || 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    // Reset during the first HIGH cycle of a store, after a nonzero load.
    access(1'b1, 1'b0, 32'd1064, 32'hA5A5_5A5A, 1'b0);
    access(1'b0, 1'b1, 32'd1064, 32'h0, 1'b0);
    @(negedge clk);
    req_wr = 1'b1; req_rd = 1'b0; req_addr = 32'd1024 + 32'd800; req_wdata = 32'h7777_8888;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_we_n", 32'(obs_we_n), 32'd0);
    check("pre_rst_addr", 32'(obs_addr), 32'(word_of(32'd1824) * 2 + 1));
    rst = 1'b0;
    #1;
    check("abort_we_n", 32'(obs_we_n), 32'd1);
    check("abort_dq_oe", 32'(obs_oe), 32'd0);
    check("abort_read_data", obs_rd, 32'd0);
    check("abort_state", 32'(obs_state), 32'd0);
    last_read[0] = '0;
    last_read[1] = '0;
    req_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(obs_ready), 32'd1);
    @(negedge clk);
    #1;
    check("post_rst_state", 32'(obs_state), 32'd0);
    check("post_rst_we_n", 32'(obs_we_n), 32'd1);

    // dut_b, WAIT_CYCLES=1.
    sel = 1'b1;
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1060, 32'h89AB_CDEF, 1'b1);
    access(1'b0, 1'b1, 32'd1060, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = rand_addr();
      w = 1'($urandom_range(0, 1));
      access(w, !w || 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
